ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction prefetch stage that sits directly upstream of the single-cycle core and drives its `instr` input. It fetches sequential instruction words from instruction memory over a request/grant/response handshake into a small in-order queue. It presents the word matching the core's current `pc`, and flushes and refetches when the core redirects on a branch or jump.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports (reset is asynchronous and active-high; one clock):
- `clk`  in  1  clock.
- `reset`  in  1  async active-high reset.
- `fetch_pc`  in  32  PC the core is executing this cycle. Bits [1:0] are ignored.
- `instr`  out  32  instruction for `fetch_pc`. Equals 32'h0000_0013 (NOP) whenever `instr_valid`=0.
- `instr_valid`  out  1  `instr` is the correct word for `fetch_pc`.
- `instr_take`  in  1  core consumes `instr` this cycle. Ignored when `instr_valid`=0.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  32  word-aligned fetch address.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  response data valid; responses return in request order.
- `mem_rdata`  in  32  response word.

## Operation
- Registers:
  - `nfa`: next fetch address.
  - `epc`: PC the core is expected to present.
  - queue: `{pc, word}` entries.
  - `outst`: accepted requests with no response yet.
  - `stale`: responses still to be discarded.
  - FSM state.
- FSM states:
  - FILL: normal operation.
  - DRAIN: discard stale responses after a redirect.
- Redirect condition: `fetch_pc[31:2] != epc[31:2]`. On redirect:
  - queue cleared;
  - `stale` ← `outst` (plus one if a grant occurs the same cycle);
  - `nfa` ← `fetch_pc`, `epc` ← `fetch_pc`;
  - state → DRAIN if the new `stale` > 0, else FILL.
- Requests:
  - `mem_req`=1 when state=FILL and `count + outst < DEPTH`.
  - On `mem_gnt`: `nfa` += 4, `outst` += 1.
  - No requests are issued in DRAIN.
- Responses:
  - In DRAIN: `mem_rvalid` decrements `stale` and the data is dropped. DRAIN → FILL when `stale` reaches 0.
  - In FILL: the response is pushed with pc = address of the oldest outstanding request.
- Output:
  - `instr_valid` = queue non-empty and head pc matches `fetch_pc`.
  - On `instr_take` with `instr_valid`=1: pop the head, `epc` += 4.
- Arithmetic: 32-bit address adds wrap modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- Boundaries:
  - Full: no request is raised. Capacity accounting (`count + outst`) makes overflow impossible.
  - Take, push and grant in the same cycle are all legal and applied together.
  - Redirect in the same cycle as `mem_rvalid`: that response is stale (dropped).
  - Redirect during DRAIN: `stale` ← `stale + outst` (plus in-cycle grant).

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `instr_valid`=0, `instr`=NOP;
  - `nfa`=`epc`=`RESET_PC`, counters 0, queue empty, state FILL.
- First `mem_req` is raised the cycle after reset deasserts.
- `mem_req` and `mem_addr` are registered. Once raised, both are held stable until the cycle `mem_gnt`=1.
  - Exception: on a redirect, `mem_req` drops the next cycle even without a grant. A not-yet-granted request is abandoned.
- Responses arrive at least one cycle after the grant.
- Response → `instr_valid` latency: 1 cycle (registered queue), unless the bypass described under Configuration is compiled in.
- Redirect → first new `mem_req`: 1 cycle when `stale`=0, otherwise 1 cycle after the last stale response.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). Responses to requests issued before reset are the memory's responsibility to cancel.

## Configuration
- `IFQ_BYPASS_EN` defined: in FILL, when the queue is empty and a response arrives whose pc matches `fetch_pc`:
  - `instr`=`mem_rdata` and `instr_valid`=1 in the same cycle (combinational path `mem_rdata`→`instr`);
  - if `instr_take`=1 the word is not pushed.
- `IFQ_BYPASS_EN` undefined: every response goes through the queue, giving 1-cycle latency. There is no combinational path from the memory inputs to `instr`/`instr_valid`.

## Structure
- Shared package `ifq_pkg`:
  - entry struct `{pc[31:0], word[31:0]}`;
  - state enum {FILL, DRAIN};
  - constant `IFQ_NOP` = 32'h0000_0013.
- Sub-module `ifq_fifo`: synchronous FIFO of entries with push, pop, clear, count and head outputs. Clear has priority over push.
- The top level holds the FSM, the address counters and the outstanding/stale counters.

## Test plan
- Reset release, memory grants every cycle, 1-cycle response latency, core takes every valid cycle:
  - `mem_addr` sequence is 0, 4, 8, …;
  - core sees words for PCs 0, 4, 8 in order;
  - `instr`=NOP before the first valid.
- Core stalls (`instr_take`=0) with DEPTH=4: `mem_req` drops after 4 entries plus outstanding reach 4, and resumes one cycle after the first take.
- Redirect to 0x100 with 2 requests outstanding:
  - the next 2 responses are dropped;
  - `mem_req` with `mem_addr`=0x100 follows the second one;
  - `instr_valid` stays 0 until the 0x100 word arrives.
- Redirect in the same cycle as `mem_gnt` and `mem_rvalid`: both words are discarded and no stale data reaches `instr`.
- Withhold `mem_gnt` for 5 cycles: `mem_addr` is held constant and `mem_req` is held high throughout.
- `RESET_PC`=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. With `IFQ_BYPASS_EN` on an empty queue, `instr_valid` rises in the response cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ifq_entry_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

  localparam logic [31:0] IFQ_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifq_fifo.sv
// In-order entry FIFO for the prefetch queue; clear wins over push.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  ifq_entry_t               din,
  output logic [$clog2(DEPTH):0]   count,
  output ifq_entry_t               head
);

  localparam int AW = $clog2(DEPTH);

  ifq_entry_t      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // entry storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue feeding the core's instr input.
// Optional IFQ_BYPASS_EN forwards a matching response to instr in its arrival cycle.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_take,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int            CW  = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

  ifq_state_e    state_r, state_s;
  logic [31:0]   nfa_r, nfa_s;
  logic [31:0]   epc_r, epc_s;
  logic [31:0]   mem_addr_r, mem_addr_s;
  logic          mem_req_r, mem_req_s;
  logic [CW-1:0] outst_r, outst_s;
  logic [CW-1:0] stale_r, stale_s;
  logic [CW-1:0] count_s, count_nxt_s;
  logic [CW:0]   stale_sum_s;
  logic [31:0]   resp_pc_s;
  logic [31:0]   pc_al_s;
  ifq_entry_t    head_s, push_entry_s;
  logic          redirect_s, gnt_s, fill_s, head_match_s, bypass_s;
  logic          take_s, push_s, pop_s;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .clear (redirect_s),
    .din   (push_entry_s),
    .count (count_s),
    .head  (head_s)
  );

  // core-side matching, queue control and output selection
  always_comb begin
    pc_al_s      = {fetch_pc[31:2], 2'b00};
    redirect_s   = (fetch_pc[31:2] != epc_r[31:2]);
    gnt_s        = mem_req_r & mem_gnt;
    fill_s       = (state_r == FILL);
    // responses return in order, so the oldest outstanding address trails nfa
    resp_pc_s    = nfa_r - 32'({outst_r, 2'b00});
    head_match_s = (count_s != '0) && (head_s.pc == pc_al_s);
`ifdef IFQ_BYPASS_EN
    bypass_s     = fill_s && !redirect_s && mem_rvalid && (count_s == '0) &&
                   (resp_pc_s == pc_al_s);
`else
    bypass_s     = 1'b0;
`endif
    instr_valid  = head_match_s | bypass_s;
    if (head_match_s) begin
      instr = head_s.word;
    end else if (bypass_s) begin
      instr = mem_rdata;
    end else begin
      instr = IFQ_NOP;
    end
    take_s            = instr_take & instr_valid;
    pop_s             = take_s & head_match_s;
    push_s            = fill_s && mem_rvalid && !redirect_s && !(bypass_s && instr_take);
    push_entry_s.pc   = resp_pc_s;
    push_entry_s.word = mem_rdata;
    if (redirect_s) begin
      count_nxt_s = '0;
    end else begin
      count_nxt_s = count_s + CW'(push_s) - CW'(pop_s);
    end
  end

  // next-state for fetch addresses, in-flight accounting and FSM
  always_comb begin
    // a response arriving in a redirect cycle retires one in-flight slot
    stale_sum_s = {1'b0, stale_r} + {1'b0, outst_r} + (CW+1)'(gnt_s) - (CW+1)'(mem_rvalid);
    if (redirect_s) begin
      nfa_s   = pc_al_s;
      epc_s   = fetch_pc;
      outst_s = '0;
      stale_s = stale_sum_s[CW-1:0];
      state_s = (stale_sum_s != '0) ? DRAIN : FILL;
    end else begin
      nfa_s = gnt_s  ? (nfa_r + 32'd4) : nfa_r;
      epc_s = take_s ? (epc_r + 32'd4) : epc_r;
      case (state_r)
        FILL: begin
          outst_s = outst_r + CW'(gnt_s) - CW'(mem_rvalid);
          stale_s = stale_r;
          state_s = FILL;
        end
        DRAIN: begin
          outst_s = outst_r + CW'(gnt_s);
          stale_s = stale_r - CW'(mem_rvalid);
          state_s = (stale_s == '0) ? FILL : DRAIN;
        end
        default: begin
          outst_s = '0;
          stale_s = '0;
          state_s = FILL;
        end
      endcase
    end
    // an ungranted request is held unless a redirect abandons it
    mem_req_s  = ((state_s == FILL) && (({1'b0, count_nxt_s} + {1'b0, outst_s}) < CAP)) ||
                 (mem_req_r && !gnt_s && !redirect_s);
    mem_addr_s = mem_req_s ? {nfa_s[31:2], 2'b00} : mem_addr_r;
  end

  // fetch engine state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FILL;
      nfa_r      <= RESET_PC;
      epc_r      <= RESET_PC;
      outst_r    <= '0;
      stale_r    <= '0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      nfa_r      <= nfa_s;
      epc_r      <= epc_s;
      outst_r    <= outst_s;
      stale_r    <= stale_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: random memory/core behaviour against a word-per-address model.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_take;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_take  (instr_take),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  // stimulus knobs (percentages) and model state
  int p_gnt, p_rsp, p_take, p_jump, lat_max;
  int cyc = 0;
  int last_take = 0;
  int grants = 0;
  logic        took;
  logic        redir_now = 1'b0;
  logic [31:0] epc_m;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] gaddr[$];
  logic [31:0] exp_q[$];

  // instruction memory contents: a distinct word for every word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case (r[1:0])
      2'd0:    return {r[31:2], 2'b00};
      2'd1:    return 32'hFFFF_FFF0 + {28'h0, r[3:2], 2'b00};
      2'd2:    return 32'h0000_0100 + {24'h0, r[7:2], 2'b00};
      default: return {16'h0, r[17:2], 2'b00};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock of stimulus: observe the finished cycle, then drive the next
  task automatic step();
    int lat;
    logic [31:0] npc;
    @(negedge clk);
    took = 1'b0;
    if (!reset) begin
      if (mem_req && mem_gnt) begin
        lat = 1 + int'($urandom_range(lat_max - 1, 0));
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + lat);
        gaddr.push_back(mem_addr);
        grants++;
      end
      if (mem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      took = instr_take && instr_valid;
      check("inflight_cap", 32'(pend_addr.size() <= DEPTH), 32'h1);
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_gnt    = mem_req && (int'($urandom_range(99, 0)) < p_gnt);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0000_0000;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc && int'($urandom_range(99, 0)) < p_rsp) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_addr[0]);
    end
    instr_take = (int'($urandom_range(99, 0)) < p_take);
    redir_now  = 1'b0;
    npc        = fetch_pc;
    if (took) begin
      epc_m = fetch_pc + 32'd4;
      npc   = epc_m;
      if (int'($urandom_range(99, 0)) < p_jump) npc = pick_target();
    end else if (int'($urandom_range(299, 0)) < p_jump) begin
      npc = pick_target();
    end
    if (took || npc != fetch_pc) begin
      if (!took && exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(mem_word(npc));
      redir_now = (npc[31:2] != epc_m[31:2]);
      epc_m     = npc;
      fetch_pc  = npc;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0000_0000;
    instr_take = 1'b0;
    fetch_pc   = RESET_PC;
    epc_m      = RESET_PC;
    redir_now  = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    gaddr.delete();
    grants = 0;
    exp_q.delete();
    exp_q.push_back(mem_word(RESET_PC));
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, IFQ_NOP);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: consume scoreboard entries and check bus protocol
  initial begin
    logic        prev_req;
    logic        prev_gnt;
    logic        prev_redir;
    logic [31:0] prev_addr;
    prev_req = 1'b0;
    prev_gnt = 1'b0;
    prev_redir = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (instr_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: instr %h valid, expected no valid word", instr);
          end else begin
            check("instr_word", instr, exp_q[0]);
            if (instr_take) begin
              void'(exp_q.pop_front());
              last_take = cyc;
            end
          end
        end else begin
          check("instr_nop", instr, IFQ_NOP);
        end
        if (prev_req && !prev_gnt && !prev_redir) begin
          check("req_hold", {31'h0, mem_req}, 32'h1);
          check("addr_hold", mem_addr, prev_addr);
        end
        if (mem_req) check("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
        prev_req   = mem_req;
        prev_gnt   = mem_gnt;
        prev_redir = redir_now;
        prev_addr  = mem_addr;
      end
    end
  end

  initial begin
    fetch_pc   = RESET_PC;
    instr_take = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0000_0000;
    epc_m      = RESET_PC;
    p_gnt = 100; p_rsp = 100; p_take = 0; p_jump = 0; lat_max = 1;
    #2;
    do_reset();

    // first request, one cycle response latency, wrap-around address sequence
    step();
    #1;
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, RESET_PC);
    step();
    #1;
`ifdef IFQ_BYPASS_EN
    check("resp_to_valid", {31'h0, instr_valid}, 32'h1);
`else
    check("resp_to_valid", {31'h0, instr_valid}, 32'h0);
`endif
    step();
    #1;
    check("first_valid", {31'h0, instr_valid}, 32'h1);
    check("first_word", instr, mem_word(RESET_PC));

    // core stalled: requests stop once queue plus in-flight reach DEPTH
    repeat (8) step();
    #1;
    check("stall_grants", 32'(grants), 32'(DEPTH));
    check("stall_req", {31'h0, mem_req}, 32'h0);
    for (int k = 0; k < DEPTH && k < gaddr.size(); k++) begin
      check("addr_seq", gaddr[k], RESET_PC + 32'(4 * k));
    end

    // one take frees a slot; the following request is then withheld
    p_take = 100;
    step();
    p_take = 0;
    p_gnt  = 0;
    step();
    #1;
    check("resume_req", {31'h0, mem_req}, 32'h1);
    check("resume_addr", mem_addr, RESET_PC + 32'(4 * DEPTH));
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      check("gnt_wait_req", {31'h0, mem_req}, 32'h1);
      check("gnt_wait_addr", mem_addr, RESET_PC + 32'(4 * DEPTH));
    end

    // randomized traffic with jumps and a mid-run reset
    p_gnt = 70; p_rsp = 75; lat_max = 4; p_take = 70; p_jump = 12;
    last_take = cyc;
    for (int i = 0; i < 2400; i++) begin
      if (i == 1200) begin
        do_reset();
        last_take = cyc;
      end
      step();
      if (cyc - last_take > 400) begin
        checks++;
        failures++;
        $display("FAIL liveness: no instruction taken for %0d cycles, limit 400", cyc - last_take);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
